io_bridge: RTL

- Parametrised memory-mapped I/O bridge between the vixen CPU bus and N peripheral slots; replaces the fixed single-window io_sel/video_sel decode in the top level.
- Decodes the I/O window and a slot index, then runs each access as a registered transaction with a per-slot acknowledge handshake.
- Adds wait-state support, byte-lane handling, a bus timeout, and sticky error capture.
- Sits between the CPU and peripherals such as videoctl and future timer/UART blocks; memory is selected when io_hit is low.

---
 rtl/io_bridge.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/io_bridge.sv
// Memory-mapped I/O bridge: decodes the CPU I/O window into N peripheral slots and
// runs each access as a registered transaction with ack handshake, timeout and error capture.
module io_bridge #(
    parameter int unsigned N_SLOTS   = 4,
    parameter int unsigned SLOT_BITS = 6,
    parameter logic [5:0]  IO_PREFIX = 6'h3f,
    parameter int unsigned TIMEOUT   = 15,
    parameter logic [15:0] ERR_DATA  = 16'hffff
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cpu_en,
    input  logic                   cpu_wr,
    input  logic                   cpu_wide,
    input  logic [15:0]            cpu_addr,
    input  logic [15:0]            cpu_wdata,
    output logic [15:0]            cpu_rdata,
    output logic                   cpu_ready,
    output logic                   io_hit,
    output logic [N_SLOTS-1:0]     slot_en,
    output logic                   slot_wr,
    output logic                   slot_wide,
    output logic [SLOT_BITS-1:0]   slot_addr,
    output logic [15:0]            slot_wdata,
    input  logic [N_SLOTS*16-1:0]  slot_rdata,
    input  logic [N_SLOTS-1:0]     slot_ack,
    input  logic                   err_clr,
    output logic                   bus_err,
    output logic [15:0]            err_addr
);
    localparam int unsigned IDX_W = 10 - SLOT_BITS;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [15:0]            addr_q, addr_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   resp_err_q, resp_err_d;

    logic [N_SLOTS-1:0]     slot_en_d;
    logic                   slot_wr_d, slot_wide_d, cpu_ready_d, bus_err_d;
    logic [SLOT_BITS-1:0]   slot_addr_d;
    logic [15:0]            slot_wdata_d, cpu_rdata_d, err_addr_d;

    logic [IDX_W-1:0]       req_idx;
    logic                   req_mapped;
    logic [15:0]            rdata_sel;
    logic                   ack_sel;

    // Byte reads return the addressed lane zero-extended; wide reads pass through.
    function automatic logic [15:0] read_fmt(input logic [15:0] d, input logic wide, input logic odd);
        if (wide)
            return d;
        return {8'h00, odd ? d[15:8] : d[7:0]};
    endfunction

    assign io_hit     = (cpu_addr[15:10] == IO_PREFIX);
    assign req_idx    = cpu_addr[9:SLOT_BITS];
    assign req_mapped = (32'(req_idx) < N_SLOTS);

    // Select the active slot's read data and ack; other slots are ignored.
    always_comb begin
        rdata_sel = '0;
        ack_sel   = 1'b0;
        for (int unsigned k = 0; k < N_SLOTS; k++) begin
            if (32'(idx_q) == k) begin
                rdata_sel = slot_rdata[16*k +: 16];
                ack_sel   = slot_ack[k];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        idx_d        = idx_q;
        resp_err_d   = resp_err_q;
        slot_en_d    = slot_en;
        slot_wr_d    = slot_wr;
        slot_wide_d  = slot_wide;
        slot_addr_d  = slot_addr;
        slot_wdata_d = slot_wdata;
        cpu_rdata_d  = cpu_rdata;
        cpu_ready_d  = 1'b0;
        bus_err_d    = bus_err & ~err_clr;
        err_addr_d   = err_addr;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (cpu_en && io_hit) begin
                    addr_d       = cpu_addr;
                    idx_d        = req_idx;
                    slot_wr_d    = cpu_wr;
                    slot_wide_d  = cpu_wide;
                    slot_addr_d  = cpu_addr[SLOT_BITS-1:0];
                    slot_wdata_d = cpu_wide ? cpu_wdata : {cpu_wdata[7:0], cpu_wdata[7:0]};
                    if (req_mapped) begin
                        slot_en_d  = N_SLOTS'(1) << req_idx;
                        resp_err_d = 1'b0;
                        state_d    = WAIT;
                    end else begin
                        resp_err_d  = 1'b1;
                        cpu_ready_d = 1'b1;
                        if (!cpu_wr)
                            cpu_rdata_d = read_fmt(ERR_DATA, cpu_wide, 1'b0);
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (ack_sel) begin
                    slot_en_d   = '0;
                    resp_err_d  = 1'b0;
                    cpu_ready_d = 1'b1;
                    if (!slot_wr)
                        cpu_rdata_d = read_fmt(rdata_sel, slot_wide, addr_q[0]);
                    state_d = RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    slot_en_d   = '0;
                    resp_err_d  = 1'b1;
                    cpu_ready_d = 1'b1;
                    if (!slot_wr)
                        cpu_rdata_d = read_fmt(ERR_DATA, slot_wide, 1'b0);
                    state_d = RESP;
                end
            end
            RESP: begin
                cnt_d   = '0;
                state_d = IDLE;
                // A new error beats a simultaneous clear; otherwise the first error address is kept.
                if (resp_err_q) begin
                    bus_err_d = 1'b1;
                    if (!bus_err || err_clr)
                        err_addr_d = addr_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            idx_q      <= '0;
            resp_err_q <= 1'b0;
            slot_en    <= '0;
            slot_wr    <= 1'b0;
            slot_wide  <= 1'b0;
            slot_addr  <= '0;
            slot_wdata <= '0;
            cpu_rdata  <= '0;
            cpu_ready  <= 1'b0;
            bus_err    <= 1'b0;
            err_addr   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            idx_q      <= idx_d;
            resp_err_q <= resp_err_d;
            slot_en    <= slot_en_d;
            slot_wr    <= slot_wr_d;
            slot_wide  <= slot_wide_d;
            slot_addr  <= slot_addr_d;
            slot_wdata <= slot_wdata_d;
            cpu_rdata  <= cpu_rdata_d;
            cpu_ready  <= cpu_ready_d;
            bus_err    <= bus_err_d;
            err_addr   <= err_addr_d;
        end
    end
endmodule
